// File: rtl/adder_tree_feeder_pkg.sv
// adder_tree_feeder_pkg: shared lane constants and sample/group types for the adder tree feeder
package adder_tree_feeder_pkg;
  localparam int NUM_LANES = 8;
  localparam int IDX_W = 3;
  localparam int DEF_TREE_LAT = 3;
  localparam int DEF_WIDTH = 8;
  typedef logic signed [DEF_WIDTH-1:0] sample_t;
  typedef sample_t group_t [NUM_LANES];
endpackage

// File: rtl/adder_tree_feeder_if.sv
// adder_tree_feeder_if: serial sample stream into the feeder
interface adder_tree_feeder_if #(parameter int WIDTH = 8);
  logic s_valid;
  logic s_ready;
  logic s_last;
  logic signed [WIDTH-1:0] s_data;
  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/tag_delay_line.sv
// tag_delay_line: DEPTH-stage shift register of N-bit tags with sync reset
module tag_delay_line #(
  parameter int DEPTH = 3,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);
  logic [N-1:0] sr_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '{default: '0};
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: gathers serial samples into 8-lane groups for the adder tree and tags its results
module adder_tree_feeder
  import adder_tree_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TREE_LAT = DEF_TREE_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_tree_feeder_if.slave      s,
  output logic signed [WIDTH-1:0] out0,
  output logic signed [WIDTH-1:0] out1,
  output logic signed [WIDTH-1:0] out2,
  output logic signed [WIDTH-1:0] out3,
  output logic signed [WIDTH-1:0] out4,
  output logic signed [WIDTH-1:0] out5,
  output logic signed [WIDTH-1:0] out6,
  output logic signed [WIDTH-1:0] out7,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    res_valid,
  output logic                    res_last,
  output logic [15:0]             grp_cnt
);
  typedef logic signed [WIDTH-1:0] lane_t;
  lane_t g_q [NUM_LANES];
  lane_t g_d [NUM_LANES];
  lane_t out_q [NUM_LANES];
  lane_t out_d [NUM_LANES];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic out_valid_q, out_last_q;
  logic [15:0] grp_cnt_q;
  logic accept, close;
  assign s.s_ready = !rst;
  assign accept = s.s_valid && s.s_ready;
  assign close = accept && (s.s_last || idx_q == IDX_W'(NUM_LANES-1));
  always_comb begin
    idx_d = close ? '0 : accept ? idx_q + IDX_W'(1) : idx_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      g_d[k] = close ? '0 : (accept && idx_q == IDX_W'(k)) ? s.s_data : g_q[k];
      out_d[k] = !close ? out_q[k] : IDX_W'(k) < idx_q ? g_q[k] : IDX_W'(k) == idx_q ? s.s_data : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= '{default: '0};
      out_q <= '{default: '0};
      idx_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      grp_cnt_q <= '0;
    end else begin
      g_q <= g_d;
      out_q <= out_d;
      idx_q <= idx_d;
      out_valid_q <= close;
      out_last_q <= close && s.s_last;
      grp_cnt_q <= grp_cnt_q + 16'(close);
    end
  end
  // tags ride alongside the tree so res_* line up with the tree result
  tag_delay_line #(.DEPTH(TREE_LAT), .N(2)) u_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({out_valid_q, out_last_q}),
    .q_o ({res_valid, res_last})
  );
  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];
  assign out4 = out_q[4];
  assign out5 = out_q[5];
  assign out6 = out_q[6];
  assign out7 = out_q[7];
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  assign grp_cnt = grp_cnt_q;
endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb_adder_tree_feeder: directed and random stimulus against a group-list reference model
module tb_adder_tree_feeder;
  import adder_tree_feeder_pkg::*;
  logic clk = 1'b0;
  logic rst;
  sample_t o [NUM_LANES];
  logic out_valid, out_last, res_valid, res_last;
  logic [15:0] grp_cnt;
  int tests = 0;
  int fails = 0;
  adder_tree_feeder_if #(.WIDTH(8)) ifc ();
  adder_tree_feeder dut (
    .clk (clk), .rst (rst), .s (ifc.slave),
    .out0 (o[0]), .out1 (o[1]), .out2 (o[2]), .out3 (o[3]),
    .out4 (o[4]), .out5 (o[5]), .out6 (o[6]), .out7 (o[7]),
    .out_valid (out_valid), .out_last (out_last),
    .res_valid (res_valid), .res_last (res_last), .grp_cnt (grp_cnt)
  );
  always #5 clk = ~clk;
  int p1, p2, p3;
  always @(posedge clk) begin
    p1 <= int'(o[0]) + int'(o[1]) + int'(o[2]) + int'(o[3]) + int'(o[4]) + int'(o[5]) + int'(o[6]) + int'(o[7]);
    p2 <= p1;
    p3 <= p2;
  end
  int cur [$];
  int eo [NUM_LANES];
  bit ev, el;
  int ecnt;
  bit hv [$];
  bit hl [$];
  int hs [$];
  task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", name, got, exp);
    end
  endtask
  task automatic model_reset();
    cur.delete();
    for (int k = 0; k < NUM_LANES; k++) eo[k] = 0;
    ev = 0; el = 0; ecnt = 0;
    hv = '{0, 0, 0}; hl = '{0, 0, 0}; hs = '{0, 0, 0};
  endtask
  task automatic step(input bit r, input bit v, input int d, input bit l);
    logic signed [7:0] b;
    bit rv, rl;
    int rs, sum;
    b = d[7:0];
    rst = r; ifc.s_valid = v; ifc.s_data = b; ifc.s_last = l;
    @(posedge clk);
    #1;
    rv = 0; rl = 0; rs = 0;
    if (r) model_reset();
    else begin
      ev = 0; el = 0; sum = 0;
      if (v) begin
        cur.push_back(int'(b));
        if (l || cur.size() == NUM_LANES) begin
          ev = 1; el = l;
          for (int k = 0; k < NUM_LANES; k++) begin
            eo[k] = k < cur.size() ? cur[k] : 0;
            sum += eo[k];
          end
          cur.delete();
          ecnt = (ecnt + 1) % 65536;
        end
      end
      rv = hv.pop_front(); rl = hl.pop_front(); rs = hs.pop_front();
      hv.push_back(ev); hl.push_back(el); hs.push_back(sum);
    end
    chk("s_ready", {31'b0, ifc.s_ready}, {31'b0, !r});
    chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
    chk("out_last", {31'b0, out_last}, {31'b0, el});
    for (int k = 0; k < NUM_LANES; k++) chk($sformatf("out%0d", k), 32'(o[k]), eo[k]);
    chk("res_valid", {31'b0, res_valid}, {31'b0, rv});
    chk("res_last", {31'b0, res_last}, {31'b0, rl});
    chk("grp_cnt", {16'b0, grp_cnt}, ecnt);
    if (rv) chk("tree_result", p3, rs);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  initial begin
    int fg [8] = '{0, -1, 2, 3, 4, 5, 6, -7};
    rst = 1; ifc.s_valid = 0; ifc.s_data = '0; ifc.s_last = 0;
    model_reset();
    step(1, 1, 5, 0);
    step(1, 1, 5, 0);
    idle(1);
    for (int i = 0; i < 8; i++) step(0, 1, fg[i], 0);
    idle(4);
    for (int i = 0; i < 8; i++) step(0, 1, -128, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 127, 0);
    idle(4);
    step(0, 1, 10, 0); step(0, 1, 15, 0); step(0, 1, 20, 1);
    step(0, 1, 9, 1);
    idle(4);
    for (int i = 0; i < 10; i++) step(0, i % 2 == 0, i + 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
    idle(4);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
    idle(1);
    step(1, 0, 0, 0);
    idle(4);
    for (int i = 1; i <= 4; i++) step(0, 1, i, 1);
    idle(4);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128, $urandom_range(0, 9) == 0);
    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
